// File: rtl/crossing_gate_ctrl_if.sv
// Signal bundle between the level-crossing controller and its field side:
// divided clock and track sensors in, motor/lamp/buzzer drives and debug state out.
interface crossing_gate_ctrl_if;
   logic       Clk190;
   logic       SensIn;
   logic       SensOut;
   logic       MotorDn;
   logic       MotorUp;
   logic       Lamp;
   logic       Buzzer;
   logic       GateClosed;
   logic [2:0] State;

   modport master (
      output Clk190, SensIn, SensOut,
      input  MotorDn, MotorUp, Lamp, Buzzer, GateClosed, State
   );

   modport slave (
      input  Clk190, SensIn, SensOut,
      output MotorDn, MotorUp, Lamp, Buzzer, GateClosed, State
   );
endinterface

// File: rtl/crossing_gate_ctrl.sv
// Level-crossing gate controller: debounces the approach/exit sensors on a tick
// derived from Clk190 and sequences warning, gate motion and clearance.
module crossing_gate_ctrl #(
   parameter int DEB_TICKS   = 4,
   parameter int WARN_TICKS  = 570,
   parameter int MOVE_TICKS  = 380,
   parameter int CLEAR_TICKS = 190,
   parameter int FLASH_TICKS = 95
) (
   input logic                 mClk,
   input logic                 Reset,
   crossing_gate_ctrl_if.slave gif
);

   function automatic int max_i(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

   localparam int MAX_TICKS = max_i(max_i(max_i(WARN_TICKS, MOVE_TICKS),
                                          max_i(CLEAR_TICKS, FLASH_TICKS)), DEB_TICKS);
   localparam int TMR_W = $clog2(MAX_TICKS) + 1;
   localparam int DEB_W = $clog2(DEB_TICKS) + 1;
   localparam int FLS_W = $clog2(FLASH_TICKS) + 1;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      WARN    = 3'd1,
      CLOSING = 3'd2,
      CLOSED  = 3'd3,
      CLEAR   = 3'd4,
      OPENING = 3'd5
   } state_t;

   // Clk190 is only ever data: synchronise, then take its rising edge as a tick
   logic c190_s1_reg, c190_s2_reg, c190_s3_reg, tick_reg;

   always_ff @(posedge mClk or posedge Reset) begin
      if (Reset) begin
         c190_s1_reg <= 1'b0;
         c190_s2_reg <= 1'b0;
         c190_s3_reg <= 1'b0;
         tick_reg    <= 1'b0;
      end else begin
         c190_s1_reg <= gif.Clk190;
         c190_s2_reg <= c190_s1_reg;
         c190_s3_reg <= c190_s2_reg;
         tick_reg    <= c190_s2_reg & ~c190_s3_reg;
      end
   end

   // Bit 0 is the approach sensor, bit 1 the exit sensor
   logic [1:0] sens_raw;
   logic [1:0] sens_evt;

   assign sens_raw = {gif.SensOut, gif.SensIn};

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_sens
         logic             s1_reg, s2_reg, lvl_reg, evt_reg;
         logic [DEB_W-1:0] cnt_reg;

         always_ff @(posedge mClk or posedge Reset) begin
            if (Reset) begin
               s1_reg  <= 1'b0;
               s2_reg  <= 1'b0;
               lvl_reg <= 1'b0;
               evt_reg <= 1'b0;
               cnt_reg <= '0;
            end else begin
               s1_reg  <= sens_raw[gi];
               s2_reg  <= s1_reg;
               evt_reg <= 1'b0;
               if (tick_reg) begin
                  if (s2_reg != lvl_reg) begin
                     if (cnt_reg == DEB_W'(DEB_TICKS - 1)) begin
                        lvl_reg <= s2_reg;
                        cnt_reg <= '0;
                        evt_reg <= s2_reg;
                     end else begin
                        cnt_reg <= cnt_reg + DEB_W'(1);
                     end
                  end else begin
                     cnt_reg <= '0;
                  end
               end
            end
         end

         assign sens_evt[gi] = evt_reg;
      end
   endgenerate

   logic in_evt, out_evt;

   assign in_evt  = sens_evt[0];
   // A simultaneous approach event takes precedence and swallows the exit event
   assign out_evt = sens_evt[1] & ~sens_evt[0];

   state_t           state_reg, state_next;
   logic             exit_pending_reg, exit_pending_next;
   logic [TMR_W-1:0] timer_reg;
   logic [TMR_W-1:0] timer_last;
   logic             expired;

   always_comb begin
      timer_last = '0;
      case (state_reg)
         WARN:             timer_last = TMR_W'(WARN_TICKS - 1);
         CLOSING, OPENING: timer_last = TMR_W'(MOVE_TICKS - 1);
         CLEAR:            timer_last = TMR_W'(CLEAR_TICKS - 1);
         default:          timer_last = '0;
      endcase
      expired = tick_reg && (timer_reg == timer_last);
   end

   always_comb begin
      state_next        = state_reg;
      exit_pending_next = exit_pending_reg;
      case (state_reg)
         IDLE: begin
            if (in_evt) state_next = WARN;
         end
         WARN: begin
            if (out_evt) exit_pending_next = 1'b1;
            if (expired) state_next = CLOSING;
         end
         CLOSING: begin
            if (out_evt) exit_pending_next = 1'b1;
            if (expired) state_next = CLOSED;
         end
         CLOSED: begin
            if (exit_pending_reg || out_evt) begin
               state_next        = CLEAR;
               exit_pending_next = 1'b0;
            end
         end
         CLEAR: begin
            if (in_evt)       state_next = CLOSED;
            else if (expired) state_next = OPENING;
         end
         OPENING: begin
            // A following train re-closes straight away without another warning
            if (in_evt)       state_next = CLOSING;
            else if (expired) state_next = IDLE;
         end
         default: begin
            state_next        = IDLE;
            exit_pending_next = 1'b0;
         end
      endcase
   end

   logic             motor_dn_reg, motor_up_reg, buzzer_reg, gate_closed_reg, lamp_reg;
   logic [FLS_W-1:0] flash_cnt_reg;

   always_ff @(posedge mClk or posedge Reset) begin
      if (Reset) begin
         state_reg        <= IDLE;
         exit_pending_reg <= 1'b0;
         timer_reg        <= '0;
         motor_dn_reg     <= 1'b0;
         motor_up_reg     <= 1'b0;
         buzzer_reg       <= 1'b0;
         gate_closed_reg  <= 1'b0;
      end else begin
         state_reg        <= state_next;
         exit_pending_reg <= exit_pending_next;
         if (state_next != state_reg) timer_reg <= '0;
         else if (tick_reg)           timer_reg <= timer_reg + TMR_W'(1);
         motor_dn_reg     <= (state_next == CLOSING);
         motor_up_reg     <= (state_next == OPENING);
         buzzer_reg       <= (state_next == WARN) || (state_next == CLOSING);
         gate_closed_reg  <= (state_next == CLOSED) || (state_next == CLEAR);
      end
   end

   // Lamp phase restarts only when a fresh warning begins out of IDLE
   always_ff @(posedge mClk or posedge Reset) begin
      if (Reset) begin
         lamp_reg      <= 1'b0;
         flash_cnt_reg <= '0;
      end else if (state_next == IDLE) begin
         lamp_reg      <= 1'b0;
         flash_cnt_reg <= '0;
      end else if (state_reg == IDLE) begin
         lamp_reg      <= 1'b1;
         flash_cnt_reg <= '0;
      end else if (tick_reg) begin
         if (flash_cnt_reg == FLS_W'(FLASH_TICKS - 1)) begin
            lamp_reg      <= ~lamp_reg;
            flash_cnt_reg <= '0;
         end else begin
            flash_cnt_reg <= flash_cnt_reg + FLS_W'(1);
         end
      end
   end

   assign gif.MotorDn    = motor_dn_reg;
   assign gif.MotorUp    = motor_up_reg;
   assign gif.Buzzer     = buzzer_reg;
   assign gif.GateClosed = gate_closed_reg;
   assign gif.Lamp       = lamp_reg;
   assign gif.State      = state_reg;

endmodule

// File: tb/tb_crossing_gate_ctrl.sv
// Bench for crossing_gate_ctrl: directed sensor pulses push expected state/dwell
// pairs into a queue that a negedge monitor pops on every State change.
module tb_crossing_gate_ctrl;
   localparam int DEB   = 2;
   localparam int WARN  = 4;
   localparam int MOVE  = 3;
   localparam int CLR   = 2;
   localparam int FLASH = 2;

   logic mClk  = 1'b0;
   logic Reset = 1'b1;
   int   checks   = 0;
   int   failures = 0;

   crossing_gate_ctrl_if gif();

   crossing_gate_ctrl #(
      .DEB_TICKS  (DEB),
      .WARN_TICKS (WARN),
      .MOVE_TICKS (MOVE),
      .CLEAR_TICKS(CLR),
      .FLASH_TICKS(FLASH)
   ) dut (
      .mClk (mClk),
      .Reset(Reset),
      .gif  (gif.slave)
   );

   always #5 mClk = ~mClk;

   task automatic chk(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         failures++;
         $display("FAIL %s: got %0d, expected %0d at %0t", name, act, req, $time);
      end
   endtask

   // Clk190: 20 mClk period, changes 2 ns after a rising mClk edge
   bit c190_en  = 1'b0;
   int rise_cnt = 0;
   initial begin
      gif.Clk190 = 1'b0;
      forever begin
         repeat (10) @(posedge mClk);
         #2;
         if (c190_en || gif.Clk190) begin
            gif.Clk190 = ~gif.Clk190;
            if (gif.Clk190) rise_cnt++;
         end
      end
   end

   bit lat_chk = 1'b0;
   always @(posedge gif.Clk190) begin
      if (lat_chk) begin
         for (int e = 1; e <= 4; e++) begin
            @(posedge mClk);
            #1;
            chk($sformatf("tick_latency_edge%0d", e), int'(dut.tick_reg), (e == 3) ? 1 : 0);
         end
      end
   end

   int tick_cnt = 0;
   always @(negedge mClk) if (dut.tick_reg) tick_cnt++;

   typedef struct {
      logic [2:0] st;
      int         dwell;
   } exp_t;

   exp_t exp_q[$];

   task automatic expect_st(input logic [2:0] s, input int d);
      exp_t it;
      it.st    = s;
      it.dwell = d;
      exp_q.push_back(it);
   endtask

   logic [2:0] last_st     = 3'd0;
   int         dwell_ticks = 0;
   int         dwell_exp   = -1;
   logic       lamp_m      = 1'b0;
   int         fcnt        = 0;

   always @(negedge mClk) begin
      exp_t       it;
      logic [2:0] st;
      logic [3:0] dec;
      st = gif.State;
      if (st != last_st) begin
         if (dwell_exp >= 0) chk($sformatf("dwell_ticks_s%0d", last_st), dwell_ticks, dwell_exp);
         if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_state: got %0d, expected to stay %0d at %0t", st, last_st, $time);
            dwell_exp = -1;
         end else begin
            it = exp_q.pop_front();
            chk("state_seq", int'(st), int'(it.st));
            dwell_exp = it.dwell;
         end
         if (last_st == 3'd0 && st == 3'd1) begin
            lamp_m = 1'b1;
            fcnt   = 0;
         end
         dwell_ticks = 0;
         last_st     = st;
      end
      if (st == 3'd0) begin
         lamp_m = 1'b0;
         fcnt   = 0;
      end
      dec = {st == 3'd2, st == 3'd5, st == 3'd1 || st == 3'd2, st == 3'd3 || st == 3'd4};
      chk("outputs_vs_state", int'({gif.MotorDn, gif.MotorUp, gif.Buzzer, gif.GateClosed}), int'(dec));
      chk("lamp", int'(gif.Lamp), int'(lamp_m));
      if (dut.tick_reg) begin
         dwell_ticks++;
         if (st != 3'd0) begin
            fcnt++;
            if (fcnt == FLASH) begin
               fcnt   = 0;
               lamp_m = ~lamp_m;
            end
         end
      end
   end

   task automatic wait_fall();
      logic prev;
      int   n;
      bit   done;
      prev = gif.Clk190;
      n    = 0;
      done = 1'b0;
      while (!done) begin
         @(negedge mClk);
         if (prev && !gif.Clk190) done = 1'b1;
         prev = gif.Clk190;
         n++;
         if (!done && n > 100) begin
            chk("clk190_fall_timeout", 1, 0);
            done = 1'b1;
         end
      end
   endtask

   task automatic pulse(input bit out_sens, input int periods);
      wait_fall();
      if (out_sens) gif.SensOut = 1'b1;
      else          gif.SensIn  = 1'b1;
      repeat (periods) wait_fall();
      if (out_sens) gif.SensOut = 1'b0;
      else          gif.SensIn  = 1'b0;
   endtask

   task automatic wait_state(input int s, input int budget);
      int n;
      n = 0;
      while (int'(gif.State) != s && n < budget) begin
         @(negedge mClk);
         n++;
      end
      chk($sformatf("reach_state_%0d", s), int'(gif.State), s);
   endtask

   task automatic wait_drain(input int budget);
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < budget) begin
         @(negedge mClk);
         n++;
      end
      chk("scoreboard_drain", exp_q.size(), 0);
      exp_q.delete();
   endtask

   initial begin
      int base;
      int n;
      gif.SensIn  = 1'b0;
      gif.SensOut = 1'b0;

      // Reset state
      repeat (3) @(posedge mClk);
      #2;
      chk("reset_state", int'(gif.State), 0);
      chk("reset_outputs", int'({gif.MotorDn, gif.MotorUp, gif.Lamp, gif.Buzzer, gif.GateClosed}), 0);
      @(negedge mClk);
      Reset = 1'b0;
      repeat (5) @(negedge mClk);
      chk("post_reset_state", int'(gif.State), 0);

      // Tick generation: 5 periods then held low
      base    = tick_cnt;
      lat_chk = 1'b1;
      c190_en = 1'b1;
      n = 0;
      while (rise_cnt < 5 && n < 500) begin
         @(negedge mClk);
         n++;
      end
      c190_en = 1'b0;
      repeat (40) @(negedge mClk);
      lat_chk = 1'b0;
      chk("tick_count_5_periods", tick_cnt - base, 5);
      base = tick_cnt;
      repeat (100) @(negedge mClk);
      chk("tick_count_held_low", tick_cnt - base, 0);
      c190_en = 1'b1;
      repeat (30) @(negedge mClk);

      // Debounce rejects
      pulse(1'b0, 1);
      repeat (100) @(negedge mClk);
      chk("deb_one_tick_ignored", int'(gif.State), 0);
      wait_fall();
      gif.SensIn = 1'b1;
      repeat (5) @(negedge mClk);
      gif.SensIn = 1'b0;
      repeat (100) @(negedge mClk);
      chk("deb_glitch_ignored", int'(gif.State), 0);

      // Full cycle
      expect_st(3'd1, WARN);
      expect_st(3'd2, MOVE);
      expect_st(3'd3, -1);
      expect_st(3'd4, CLR);
      expect_st(3'd5, MOVE);
      expect_st(3'd0, -1);
      pulse(1'b0, 2);
      wait_state(3, 400);
      pulse(1'b1, 2);
      wait_drain(600);
      repeat (60) @(negedge mClk);

      // Early exit during WARN
      expect_st(3'd1, WARN);
      expect_st(3'd2, MOVE);
      expect_st(3'd3, 0);
      expect_st(3'd4, CLR);
      expect_st(3'd5, MOVE);
      expect_st(3'd0, -1);
      pulse(1'b0, 2);
      wait_state(1, 100);
      pulse(1'b1, 2);
      wait_state(3, 400);
      @(negedge mClk);
      chk("early_exit_clear_next_cycle", int'(gif.State), 4);
      wait_drain(600);
      repeat (60) @(negedge mClk);

      // Following train in CLEAR, then re-close from OPENING at timer=1
      expect_st(3'd1, WARN);
      expect_st(3'd2, MOVE);
      expect_st(3'd3, -1);
      expect_st(3'd4, 1);
      expect_st(3'd3, -1);
      expect_st(3'd4, CLR);
      expect_st(3'd5, 1);
      expect_st(3'd2, MOVE);
      expect_st(3'd3, -1);
      expect_st(3'd4, CLR);
      expect_st(3'd5, MOVE);
      expect_st(3'd0, -1);
      pulse(1'b0, 2);
      wait_state(3, 400);
      wait_fall();
      gif.SensOut = 1'b1;
      wait_fall();
      gif.SensIn = 1'b1;
      wait_fall();
      gif.SensOut = 1'b0;
      wait_fall();
      gif.SensIn = 1'b0;
      wait_state(3, 100);
      repeat (3) wait_fall();
      pulse(1'b1, 2);
      pulse(1'b0, 2);
      wait_state(2, 200);
      wait_state(3, 400);
      pulse(1'b1, 2);
      wait_drain(800);
      repeat (60) @(negedge mClk);

      // Asynchronous reset mid-CLOSING
      expect_st(3'd1, WARN);
      expect_st(3'd2, -1);
      expect_st(3'd0, -1);
      pulse(1'b0, 2);
      wait_state(2, 400);
      repeat (20) @(posedge mClk);
      #1;
      chk("motor_dn_before_reset", int'(gif.MotorDn), 1);
      #2;
      Reset = 1'b1;
      #1;
      chk("async_reset_state", int'(gif.State), 0);
      chk("async_reset_outputs", int'({gif.MotorDn, gif.MotorUp, gif.Lamp, gif.Buzzer, gif.GateClosed}), 0);
      repeat (3) @(negedge mClk);
      Reset = 1'b0;
      repeat (200) @(negedge mClk);
      chk("idle_after_reset_release", int'(gif.State), 0);
      wait_drain(10);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #1000000;
      failures++;
      $display("FAIL watchdog: simulation time limit reached at %0t", $time);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/crossing_gate_ctrl.md
Name: crossing_gate_ctrl

Overview:
- Gate/signal controller for the automatic level crossing; sits directly downstream of the slow-clock divider and consumes its Clk190 output.
- Clk190 is never used as a clock. It is synchronised into mClk and edge-detected into a one-cycle tick enable. All debouncing, timing and lamp flashing advance on that tick.
- Drives the gate motor, warning lamp and buzzer from two track sensors: approach (SensIn) and exit (SensOut).

Parameters:
DEB_TICKS, 4, consecutive agreeing tick samples needed to change a debounced sensor level
WARN_TICKS, 570, ticks of lamp+buzzer warning before gate starts closing (~3 s)
MOVE_TICKS, 380, ticks the motor is driven for a full close or open (~2 s)
CLEAR_TICKS, 190, ticks gate stays closed after exit detection (~1 s)
FLASH_TICKS, 95, ticks per lamp on/off half-period

Ports:
mClk      in   1  system clock
Reset     in   1  asynchronous, active-high reset
Clk190    in   1  divided clock from divider; sampled as data only
SensIn    in   1  raw approach sensor, active-high, asynchronous
SensOut   in   1  raw exit sensor, active-high, asynchronous
MotorDn   out  1  gate motor close drive
MotorUp   out  1  gate motor open drive
Lamp      out  1  warning lamp
Buzzer    out  1  warning buzzer
GateClosed out 1  gate fully down
State     out  3  FSM state code, for debug/LEDs

Behaviour:
- Reset: Reset is asynchronous, active-high; clock is mClk. All flops clear: State=IDLE(0), all outputs 0, timers 0, debounced levels 0, exit_pending 0.
- Tick generation:
  - Clk190 passes through a 2-FF synchroniser.
  - tick=1 for exactly one mClk cycle when sync2=1 and the previous sync2=0.
  - Latency: 3 mClk edges after the Clk190 rise.
- Sensor conditioning:
  - Each sensor passes through a 2-FF synchroniser and is sampled only on tick.
  - The debounced level flips after DEB_TICKS consecutive samples that differ from it; any agreeing sample resets the count.
  - in_evt / out_evt = one-cycle pulse on the debounced 0->1 transition.
- Timer:
  - Single shared tick counter, width ceil(log2(max param)) + 1.
  - Cleared on every state entry; increments on tick.
  - "Expires" on the tick where timer == N-1.
- FSM transitions (registered outputs, update the cycle after the condition):
  - IDLE(0): in_evt -> WARN.
  - WARN(1): Lamp flashing, Buzzer=1. Expires at WARN_TICKS -> CLOSING.
  - CLOSING(2): MotorDn=1, Lamp flashing, Buzzer=1. Expires at MOVE_TICKS -> CLOSED.
  - CLOSED(3): GateClosed=1, Lamp flashing. Entry with exit_pending=1, or out_evt -> CLEAR; clears exit_pending.
  - CLEAR(4): GateClosed=1, Lamp flashing. in_evt -> CLOSED (following train). Expires at CLEAR_TICKS -> OPENING.
  - OPENING(5): MotorUp=1, Lamp flashing. in_evt -> CLOSING, timer cleared, no repeat warning. Expires at MOVE_TICKS -> IDLE.
  - Codes 6/7: unreachable; force IDLE on the next cycle.
- Event priority and ignored events:
  - out_evt in WARN or CLOSING sets exit_pending.
  - out_evt in IDLE or OPENING is ignored.
  - in_evt in WARN, CLOSING or CLOSED is ignored.
  - If in_evt and out_evt occur in the same cycle, in_evt wins; out_evt is dropped in that cycle.
- Output invariants:
  - MotorDn and MotorUp are never both 1.
  - Buzzer is 0 outside WARN/CLOSING.
  - GateClosed=1 only in CLOSED/CLEAR.
- Lamp:
  - Turns on on the cycle of WARN entry; the flash counter restarts there.
  - Toggles every FLASH_TICKS ticks while State != IDLE.
  - Forced 0 in IDLE.
- Reset mid-operation: immediate return to the reset values, motor drives dropped asynchronously.

Test Plan:
(Bench overrides: DEB_TICKS=2, WARN_TICKS=4, MOVE_TICKS=3, CLEAR_TICKS=2, FLASH_TICKS=2; Clk190 square wave, 20 mClk period.)
- Tick gen: 5 Clk190 periods -> exactly 5 one-cycle ticks, each 3 mClk edges after a Clk190 rise; Clk190 held low -> no ticks.
- Debounce: SensIn high for 1 tick then low -> State stays 0; SensIn high for 2 ticks -> single in_evt, State=1; glitch of 5 mClk between ticks -> ignored.
- Full cycle: SensIn pulse, then SensOut pulse once in CLOSED -> States 0->1->2->3->4->5->0. Dwell: 4 ticks in WARN, 3 in CLOSING, 2 in CLEAR, 3 in OPENING. MotorDn high only in 2; MotorUp high only in 5; Lamp toggles every 2 ticks; Buzzer only in 1-2.
- Early exit: SensOut pulse during WARN -> CLOSED entered, then CLEAR on the next cycle with no further sensor activity.
- Re-close: SensIn pulse during OPENING at timer=1 -> CLOSING, MotorUp falls and MotorDn rises on the same edge, 3 full ticks of closing. SensIn during CLEAR -> back to CLOSED.
- Reset: assert Reset mid-CLOSING, asynchronously between clock edges -> all outputs 0 and State=0 before the next mClk edge; after release, State=0 until a new in_evt.
